// File: rtl/next_gen_engine_if.sv
// Row-file port bundle between the life engine and the storage that holds the grid.
// The engine reads one row per cycle (rd is combinational from ra) and writes one row per cycle.
interface next_gen_engine_if;
  logic [7:0] rd;
  logic [2:0] ra;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       regwrite;

  modport master (input rd, output ra, output wa, output wd, output regwrite);
  modport slave  (output rd, input ra, input wa, input wd, input regwrite);
endinterface

// File: rtl/next_gen_engine.sv
// One-generation Game of Life stepper for an 8x8 toroidal grid, updated in place row by row.
// state | meaning
// IDLE  | waiting for start
// LOAD0 | fetch row 7 into prev
// LOAD1 | fetch row 0 into cur and keep a copy for the final wrap
// LOAD2 | fetch row 1 into nxt
// ROW   | write next-gen row r, slide the 3-row window down
// DONE  | one-cycle done pulse, bump gen_count
module next_gen_engine (
  input  logic                     ph1,
  input  logic                     reset,
  input  logic                     start,
  next_gen_engine_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               gen_count
);

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, ROW, DONE} state_t;

  state_t     r_state;
  logic [7:0] r_prev;
  logic [7:0] r_cur;
  logic [7:0] r_nxt;
  logic [7:0] r_row0;
  logic [2:0] r_idx;

  logic [7:0] w_np;
  logic [7:0] w_nc;
  logic [7:0] w_nn;
  logic [7:0] w_row;

  function automatic logic [7:0] life_row(input logic [7:0] p, input logic [7:0] c,
                                          input logic [7:0] n);
    logic [7:0] res;
    logic [2:0] ci;
    logic [2:0] cl;
    logic [2:0] cr;
    logic [3:0] cnt;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      ci  = 3'(i);
      cl  = ci - 3'd1;
      cr  = ci + 3'd1;
      cnt = 4'(p[cl]) + 4'(p[ci]) + 4'(p[cr]) + 4'(c[cl]) + 4'(c[cr])
          + 4'(n[cl]) + 4'(n[ci]) + 4'(n[cr]);
      res[i] = (cnt == 4'd3) || (c[ci] && (cnt == 4'd2));
    end
    return res;
  endfunction

  // wd is registered, so compute the row for the window as it will be next cycle
  always_comb begin
    w_np = r_cur;
    w_nc = r_nxt;
    w_nn = (r_idx == 3'd6) ? r_row0 : bus.rd;
    if (r_state == LOAD2) begin
      w_np = r_prev;
      w_nc = r_cur;
      w_nn = bus.rd;
    end
    w_row = life_row(w_np, w_nc, w_nn);
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_cur        <= '0;
      r_nxt        <= '0;
      r_row0       <= '0;
      r_idx        <= '0;
      bus.ra       <= '0;
      bus.wa       <= '0;
      bus.wd       <= '0;
      bus.regwrite <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      gen_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD0;
            busy    <= 1'b1;
            bus.ra  <= 3'd7;
          end
        end
        LOAD0: begin
          r_prev  <= bus.rd;
          bus.ra  <= 3'd0;
          r_state <= LOAD1;
        end
        LOAD1: begin
          r_cur   <= bus.rd;
          r_row0  <= bus.rd;
          bus.ra  <= 3'd1;
          r_state <= LOAD2;
        end
        LOAD2: begin
          r_nxt        <= bus.rd;
          r_idx        <= 3'd0;
          bus.ra       <= 3'd2;
          bus.regwrite <= 1'b1;
          bus.wa       <= 3'd0;
          bus.wd       <= w_row;
          r_state      <= ROW;
        end
        ROW: begin
          r_prev <= r_cur;
          r_cur  <= r_nxt;
          r_nxt  <= w_nn;
          if (r_idx == 3'd7) begin
            bus.regwrite <= 1'b0;
            done         <= 1'b1;
            gen_count    <= gen_count + 8'd1;
            r_state      <= DONE;
          end else begin
            r_idx  <= r_idx + 3'd1;
            bus.ra <= r_idx + 3'd3;
            bus.wa <= r_idx + 3'd1;
            bus.wd <= w_row;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_next_gen_engine.sv
// Directed bench for next_gen_engine: a behavioural row file around the DUT and hand-computed grids.
module tb_next_gen_engine;
  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] gen_count;

  next_gen_engine_if bus();

  logic [7:0] mem [8];
  logic [7:0] load_grid [8];
  logic       load_en = 1'b0;

  int total = 0;
  int bad = 0;

  int busy_cycles;
  int done_cnt;
  int done_cycle;
  logic [2:0] wa_log[$];

  assign bus.rd = mem[bus.ra];

  always #5 ph1 = ~ph1;

  always @(posedge ph1) begin
    if (load_en) begin
      for (int i = 0; i < 8; i++) mem[i] <= load_grid[i];
    end else if (bus.regwrite) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  next_gen_engine dut (
    .ph1       (ph1),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count)
  );

  task automatic set_grid(input logic [63:0] g);
    @(negedge ph1);
    for (int i = 0; i < 8; i++) load_grid[i] = g[8*i +: 8];
    load_en = 1'b1;
    @(negedge ph1);
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    reset = 1'b0;
  endtask

  // Pulse start for one edge and record busy/done/write activity until back in IDLE.
  task automatic run_gen();
    busy_cycles = 0;
    done_cnt    = 0;
    done_cycle  = -1;
    wa_log.delete();
    @(negedge ph1);
    start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge ph1);
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        done_cycle = cyc;
      end
      if (bus.regwrite) wa_log.push_back(bus.wa);
      if (cyc > 12 && !busy) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge ph1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    total++; if (gen_count !== 8'd0) begin bad++; $display("FAIL reset_gen_count: got %0d expected 0", gen_count); end
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite: got %0b expected 0", bus.regwrite); end
    total++; if (bus.ra !== 3'd0) begin bad++; $display("FAIL reset_ra: got %0d expected 0", bus.ra); end
    total++; if (bus.wa !== 3'd0) begin bad++; $display("FAIL reset_wa: got %0d expected 0", bus.wa); end
    total++; if (bus.wd !== 8'd0) begin bad++; $display("FAIL reset_wd: got %0h expected 0", bus.wd); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge ph1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after: got %0b expected 0", busy); end
  endtask

  task automatic test_blinker();
    logic [63:0] exp;
    set_grid(64'h00000008_08080000);
    run_gen();
    exp = 64'h00000000_1C000000;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== exp[8*i +: 8]) begin
        bad++; $display("FAIL blinker_row%0d: got %02h expected %02h", i, mem[i], exp[8*i +: 8]);
      end
    end
    total++; if (busy_cycles !== 12) begin bad++; $display("FAIL blinker_busy_cycles: got %0d expected 12", busy_cycles); end
    total++; if (done_cycle !== 12) begin bad++; $display("FAIL blinker_done_cycle: got %0d expected 12", done_cycle); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL blinker_done_count: got %0d expected 1", done_cnt); end
    total++; if (gen_count !== 8'd1) begin bad++; $display("FAIL blinker_gen_count: got %0d expected 1", gen_count); end
  endtask

  task automatic test_block();
    logic [63:0] exp;
    exp = 64'h00000000_00181800;
    set_grid(exp);
    run_gen();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== exp[8*i +: 8]) begin
        bad++; $display("FAIL block_row%0d: got %02h expected %02h", i, mem[i], exp[8*i +: 8]);
      end
    end
    total++; if (wa_log.size() !== 8) begin bad++; $display("FAIL block_write_count: got %0d expected 8", wa_log.size()); end
    for (int i = 0; i < wa_log.size(); i++) begin
      total++;
      if (wa_log[i] !== 3'(i)) begin bad++; $display("FAIL block_wa_order%0d: got %0d expected %0d", i, wa_log[i], i); end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp;
    set_grid(64'h00000000_00000083);
    run_gen();
    exp = 64'h01000000_00000101;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== exp[8*i +: 8]) begin
        bad++; $display("FAIL wrap_row%0d: got %02h expected %02h", i, mem[i], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic test_all_ones();
    set_grid(64'hFFFFFFFF_FFFFFFFF);
    run_gen();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== 8'h00) begin bad++; $display("FAIL ones_row%0d: got %02h expected 00", i, mem[i]); end
    end
  endtask

  task automatic test_gen_wrap();
    int odd_runs;
    odd_runs = 0;
    do_reset();
    set_grid(64'h0);
    for (int g = 0; g < 256; g++) begin
      run_gen();
      if (busy_cycles != 12 || done_cnt != 1) odd_runs++;
      if (g == 254) begin
        total++; if (gen_count !== 8'd255) begin bad++; $display("FAIL genwrap_255: got %0d expected 255", gen_count); end
      end
    end
    total++; if (odd_runs !== 0) begin bad++; $display("FAIL genwrap_runs: got %0d irregular runs expected 0", odd_runs); end
    total++; if (gen_count !== 8'd0) begin bad++; $display("FAIL genwrap_count: got %0d expected 0", gen_count); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== 8'h00) begin bad++; $display("FAIL genwrap_row%0d: got %02h expected 00", i, mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int first_idle;
    int d1;
    int d2;
    first_idle = -1;
    d1 = -1;
    d2 = -1;
    do_reset();
    exp = 64'h00000008_08080000;
    set_grid(exp);
    @(negedge ph1);
    start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge ph1);
      if (cyc == 20) start = 1'b0;
      if (!busy && first_idle < 0) first_idle = cyc;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
        else d2 = 99;
      end
    end
    start = 1'b0;
    total++; if (d1 !== 12) begin bad++; $display("FAIL b2b_done1: got %0d expected 12", d1); end
    total++; if (first_idle !== 13) begin bad++; $display("FAIL b2b_idle_gap: got %0d expected 13", first_idle); end
    total++; if (d2 !== 25) begin bad++; $display("FAIL b2b_done2: got %0d expected 25", d2); end
    total++; if (gen_count !== 8'd2) begin bad++; $display("FAIL b2b_gen_count: got %0d expected 2", gen_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_settled: got %0b expected 0", busy); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== exp[8*i +: 8]) begin
        bad++; $display("FAIL b2b_row%0d: got %02h expected %02h", i, mem[i], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rows_seen;
    int late_writes;
    bit hit;
    rows_seen = 0;
    late_writes = 0;
    hit = 1'b0;
    set_grid(64'hFFFFFFFF_FFFFFFFF);
    @(negedge ph1);
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge ph1);
      start = 1'b0;
      if (bus.regwrite) rows_seen++;
      if (rows_seen == 3) begin
        hit = 1'b1;
        break;
      end
    end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL mid_reach_row3: got %0d rows expected 3", rows_seen); end
    reset = 1'b1;
    @(negedge ph1);
    reset = 1'b0;
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("FAIL mid_regwrite: got %0b expected 0", bus.regwrite); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    total++; if (gen_count !== 8'd0) begin bad++; $display("FAIL mid_gen_count: got %0d expected 0", gen_count); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %0b expected 0", done); end
    repeat (15) begin
      @(negedge ph1);
      if (bus.regwrite || busy) late_writes++;
    end
    total++; if (late_writes !== 0) begin bad++; $display("FAIL mid_late_activity: got %0d expected 0", late_writes); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[i] !== ((i < 3) ? 8'h00 : 8'hFF)) begin
        bad++; $display("FAIL mid_row%0d: got %02h expected %02h", i, mem[i], (i < 3) ? 8'h00 : 8'hFF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_wrap();
    test_all_ones();
    test_gen_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
